// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller:
// state encoding and the bit-counter width helper.
package sipo_ctrl_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_t;

    // Counter width able to index WIDTH bits; never narrower than one bit.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift-left serial-in/parallel-out register. Clear has priority over shift.
module sipo_shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Shift register: clear, shift one bit in at the LSB, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{1'b0}};
        end else if (clr) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller around sipo_shift_core: counts WIDTH qualified bits per
// frame, hands the finished word to a valid/ready consumer and flags frames
// dropped because the consumer was still holding the previous word.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             word_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t            state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [WIDTH-1:0]  sreg_s;
    logic [WIDTH-1:0]  done_word_s;
    logic              shift_clr_s;
    logic              shift_en_s;
    logic              frame_done_s;
    logic              accept_s;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_shift_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (shift_clr_s),
        .en    (shift_en_s),
        .din   (serial_in),
        .q     (sreg_s)
    );

    // The completed word includes the bit arriving this cycle.
    assign done_word_s = {sreg_s[WIDTH-2:0], serial_in};

    // Shift-core control and frame-completion decode; start always wins.
    always_comb begin
        shift_clr_s  = 1'b0;
        shift_en_s   = 1'b0;
        frame_done_s = 1'b0;
        if (start) begin
            shift_clr_s = 1'b1;
        end else if ((state_r == S_SHIFT) && bit_valid) begin
            shift_en_s   = 1'b1;
            frame_done_s = (bit_cnt_r == LAST_CNT);
        end else begin
            shift_clr_s = 1'b0;
        end
    end

    // The holding register can take a new word if empty or being drained now.
    always_comb begin
        accept_s = 1'b0;
        if (!word_valid || word_ready) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // FSM, bit counter and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            busy      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r   <= S_SHIFT;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= S_IDLE;
                        bit_cnt_r <= bit_cnt_r;
                        busy      <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (start) begin
                        state_r   <= S_SHIFT;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        busy      <= 1'b1;
                    end else if (frame_done_s) begin
                        state_r   <= S_IDLE;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        busy      <= 1'b0;
                    end else if (bit_valid) begin
                        state_r   <= S_SHIFT;
                        bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= S_SHIFT;
                        bit_cnt_r <= bit_cnt_r;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    bit_cnt_r <= {CNT_W{1'b0}};
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register and valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= {WIDTH{1'b0}};
            word_valid <= 1'b0;
        end else if (frame_done_s && accept_s) begin
            word_out   <= done_word_s;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_out   <= word_out;
            word_valid <= 1'b0;
        end else begin
            word_out   <= word_out;
            word_valid <= word_valid;
        end
    end

    // Sticky overrun: a dropped frame sets it and beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (frame_done_s && !accept_s) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun;
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl with WIDTH=8.
module tb_sipo_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       bit_valid;
    logic       serial_in;
    logic       word_ready;
    logic       clr_overrun;
    logic [7:0] word_out;
    logic       word_valid;
    logic       busy;
    logic       overrun;

    int n_checks;
    int n_fails;

    sipo_frame_ctrl #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bit_valid   (bit_valid),
        .serial_in   (serial_in),
        .word_ready  (word_ready),
        .clr_overrun (clr_overrun),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] w, input logic v,
                              input logic b, input logic o);
        check_eq({tag, "_word_out"},   32'(word_out),   32'(w));
        check_eq({tag, "_word_valid"}, 32'(word_valid), 32'(v));
        check_eq({tag, "_busy"},       32'(busy),       32'(b));
        check_eq({tag, "_overrun"},    32'(overrun),    32'(o));
    endtask

    // Start cycle (optionally with a junk bit_valid), then 8 bits MSB-first
    // with 'gap' idle cycles before each. Optionally raise word_ready and/or
    // clr_overrun only on the last-bit cycle. Returns at the negedge after
    // the last bit edge, i.e. when the delivered word is visible.
    task automatic send_frame(input logic [7:0] w, input int gap, input logic junk,
                              input logic rdy_last, input logic clr_last);
        start     = 1'b1;
        bit_valid = junk;
        serial_in = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            repeat (gap) @(negedge clk);
            bit_valid = 1'b1;
            serial_in = w[i];
            if (i == 0) begin
                if (rdy_last) word_ready = 1'b1;
                if (clr_last) clr_overrun = 1'b1;
            end
            @(negedge clk);
            bit_valid = 1'b0;
            serial_in = 1'b0;
            if (i == 0) begin
                if (rdy_last) word_ready = 1'b0;
                if (clr_last) clr_overrun = 1'b0;
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        bit_valid   = 1'b0;
        serial_in   = 1'b0;
        word_ready  = 1'b0;
        clr_overrun = 1'b0;

        repeat (2) @(negedge clk);
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, consumer ready.
        word_ready = 1'b1;
        send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0);
        check_outs("basic", 8'hA5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("basic_drained", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Leave a word held, then reset mid-frame after 3 bits.
        word_ready = 1'b0;
        send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0);
        check_outs("held", 8'h5A, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            serial_in = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        check_eq("busy_mid_frame", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outs("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        word_ready = 1'b1;
        send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b0);
        check_outs("after_reset", 8'h3C, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // Gapped frame; bit_valid in IDLE and on the start cycle ignored.
        bit_valid = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        bit_valid = 1'b0;
        check_eq("idle_bits_ignored_busy", 32'(busy), 32'd0);
        send_frame(8'h81, 2, 1'b1, 1'b0, 1'b0);
        check_outs("gapped", 8'h81, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("gapped_drained", 32'(word_valid), 32'd0);

        // Stall and overrun.
        word_ready = 1'b0;
        send_frame(8'h11, 0, 1'b0, 1'b0, 1'b0);
        check_outs("stall_first", 8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 0, 1'b0, 1'b0, 1'b0);
        check_outs("stall_dropped", 8'h11, 1'b1, 1'b0, 1'b1);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check_outs("stall_drain", 8'h11, 1'b0, 1'b0, 1'b1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check_eq("overrun_cleared", 32'(overrun), 32'd0);

        // Simultaneous consume and complete.
        send_frame(8'h55, 0, 1'b0, 1'b0, 1'b0);
        check_outs("sim_held", 8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(8'hAA, 0, 1'b0, 1'b1, 1'b0);
        check_outs("sim_replace", 8'hAA, 1'b1, 1'b0, 1'b0);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        check_eq("sim_drained", 32'(word_valid), 32'd0);

        // Restart after 5 bits of 0xFF, then a full 0x0F.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            serial_in = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        send_frame(8'h0F, 0, 1'b0, 1'b0, 1'b0);
        check_outs("restart", 8'h0F, 1'b1, 1'b0, 1'b0);

        // Overrun set and clear in the same cycle: set wins.
        send_frame(8'h33, 0, 1'b0, 1'b0, 1'b1);
        check_outs("set_beats_clear", 8'h0F, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Frame controller for a parameterized shift-left serial-in/parallel-out register. It sequences the shift register: it starts a frame on command, shifts in exactly WIDTH qualified serial bits MSB-first, and transfers the finished word into an output holding register. The word is delivered over a valid/ready handshake and an overrun is flagged when the consumer stalls. It sits between a bit-level serial source and a word-level consumer.

Parameters:
WIDTH, 8, word length in bits; legal range is 2 or greater.
CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a new frame
bit_valid  input  1  serial_in carries a valid bit this cycle
serial_in  input  1  serial data bit, MSB of the word first
word_ready  input  1  consumer accepts word_out this cycle
clr_overrun  input  1  synchronous clear of the overrun flag
word_out  output  WIDTH  assembled word, registered
word_valid  output  1  word_out holds an unconsumed word
busy  output  1  frame in progress (state SHIFT)
overrun  output  1  sticky flag: a completed frame was dropped

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, shift reg=0, bit_cnt=0.
  - word_out=0, word_valid=0, busy=0, overrun=0.
  - Reset asserted mid-frame discards the partial word immediately.
- States:
  - IDLE: bit_valid is ignored. start=1 -> SHIFT, with shift reg cleared and bit_cnt=0.
  - SHIFT: busy=1. Each bit_valid=1 sets sreg <= {sreg[WIDTH-2:0], serial_in} and bit_cnt+1.
  - SHIFT, last bit: bit_valid=1 with bit_cnt==WIDTH-1 completes the frame and returns to IDLE with bit_cnt=0.
- Start cycle: bit_valid on the same cycle as start is ignored. The first data bit must come on a later cycle.
- Restart: start during SHIFT clears sreg and bit_cnt and stays in SHIFT. The partial frame is silently dropped and no flag is set.
- Restart on the last bit: start wins, and the frame does not complete.
- Completion handoff:
  - The completed word is {sreg[WIDTH-2:0], serial_in}.
  - If word_valid=0, or word_ready=1 in the same cycle: word_out <= completed word and word_valid=1 on the next edge. Latency is 1 clk after the last bit_valid.
  - Otherwise the word is dropped, word_out is unchanged and overrun is set.
- Handshake:
  - A transfer occurs on an edge where word_valid=1 and word_ready=1.
  - word_out is stable while word_valid=1 and no transfer occurs.
  - On a transfer with no completion in the same cycle, word_valid falls and word_out holds its last value.
  - word_ready while word_valid=0 has no effect.
- overrun: sticky. It is cleared by clr_overrun; if set and clear happen in the same cycle, set wins.
- Back-to-back frames: start may be asserted on the cycle after completion. The minimum frame period is WIDTH+1 cycles.
- bit_valid may have gaps of any length, and bit_cnt holds across gaps.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Package sipo_ctrl_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - constant function for the counter width.
- Sub-module sipo_shift_core (WIDTH):
  - shift-left register with shift enable and synchronous clear.
  - ports: clk, rst_n, clr, en, din, q.
  - the controller instantiates it once and drives clr/en from the FSM.
- Top-level: FSM, bit counter, output holding register, handshake and overrun logic.

Test Plan:
- Reset mid-frame: WIDTH=8. Assert rst_n=0 after 3 bits -> all outputs 0 asynchronously. After release, a new frame of 0x3C -> word_out=0x3C.
- Basic frame: start, then bits of 0xA5 MSB-first on consecutive cycles, word_ready=1 -> word_valid=1 and word_out=0xA5 one clk after the 8th bit, valid for one cycle, busy low by then.
- Gapped frame: 0x81 with 2 idle cycles between every bit -> word_out=0x81. bit_valid in IDLE and on the start cycle does not alter the result.
- Stall and overrun: word_ready=0; frames 0x11 then 0x22 -> word_out stays 0x11 and overrun=1. Then word_ready=1 -> 0x11 transferred and word_valid=0. clr_overrun -> overrun=0.
- Simultaneous consume and complete: word_valid=1 with 0x55 held; word_ready=1 on the last-bit cycle of 0xAA -> word_out=0xAA, word_valid stays 1, overrun=0.
- Restart: start after 5 bits of 0xFF, then a full 0x0F -> only 0x0F is delivered and overrun=0. clr_overrun and set in the same cycle -> overrun=1.
